// File: rtl/udp_tx_pkg.sv
// Shared types and elaboration-time helpers for the UDP TX admission controller.
package udp_tx_pkg;

    // Controller states; the encoding is shared with any checker or debug logic.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DROP = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    localparam int FRAME_CNT_W = 16;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            res = res + (((32'd1 << i) < value) ? 32'sd1 : 32'sd0);
        end
        return res;
    endfunction

    // Channel index width; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // Beat counter must be able to hold P_MAX_LEN itself.
    function automatic int beat_cnt_w(input int max_len);
        return clog2(max_len + 1);
    endfunction

    // Gap counter covers both the runtime config and the default gap.
    function automatic int gap_cnt_w(input int gap_w, input int frame_gap);
        return (gap_w > clog2(frame_gap + 1)) ? gap_w : clog2(frame_gap + 1);
    endfunction

endpackage

// File: rtl/udp_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, wrapping to 0.
module udp_rr_arbiter
    import udp_tx_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic             hit_hi_s;
    logic [IDX_W-1:0] idx_hi_s;
    logic [IDX_W-1:0] idx_lo_s;

    // Lowest requester at/after the pointer wins, else the lowest requester overall.
    always_comb begin
        hit_hi_s = 1'b0;
        idx_hi_s = '0;
        idx_lo_s = '0;
        for (int j = N - 1; j >= 0; j--) begin
            hit_hi_s = (req[j] && (j >= int'(ptr))) ? 1'b1 : hit_hi_s;
            idx_hi_s = (req[j] && (j >= int'(ptr))) ? IDX_W'(j) : idx_hi_s;
            idx_lo_s = req[j] ? IDX_W'(j) : idx_lo_s;
        end
        gnt_any = |req;
        gnt_idx = hit_hi_s ? idx_hi_s : idx_lo_s;
        for (int j = 0; j < N; j++) begin
            gnt_oh[j] = gnt_any && (gnt_idx == IDX_W'(j));
        end
    end

endmodule

// File: rtl/udp_tx_ready_ctrl.sv
// Multi-channel UDP TX admission controller: round-robin frame grant, inter-frame gap,
// maximum-length truncation, beat pass-through to the MAC.
module udp_tx_ready_ctrl
    import udp_tx_pkg::*;
#(
    parameter int P_FRAME_GAP = 12,
    parameter int P_CHANNELS  = 2,
    parameter int P_DATA_W    = 8,
    parameter int P_MAX_LEN   = 1500,
    parameter int P_GAP_W     = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [P_GAP_W-1:0]             i_gap_cfg,
    input  logic [P_CHANNELS-1:0]          i_req,
    input  logic [P_CHANNELS-1:0]          i_valid,
    input  logic [P_CHANNELS-1:0]          i_last,
    input  logic [P_CHANNELS*P_DATA_W-1:0] i_data,
    output logic [P_CHANNELS-1:0]          o_ready,
    output logic                           o_valid,
    output logic                           o_last,
    output logic [P_DATA_W-1:0]            o_data,
    output logic [idx_w(P_CHANNELS)-1:0]   o_chan,
    input  logic                           i_mac_ready,
    output logic                           o_busy,
    output logic                           o_trunc,
    output logic [FRAME_CNT_W-1:0]         o_frame_cnt
);

    localparam int CHAN_W    = idx_w(P_CHANNELS);
    localparam int BEAT_W    = beat_cnt_w(P_MAX_LEN);
    localparam int GAP_CNT_W = gap_cnt_w(P_GAP_W, P_FRAME_GAP);

    tx_state_e              state_r;
    tx_state_e              state_nx_s;
    logic [CHAN_W-1:0]      ptr_r;
    logic [CHAN_W-1:0]      grant_r;
    logic [P_CHANNELS-1:0]  grant_oh_r;
    logic [CHAN_W-1:0]      arb_idx_s;
    logic [P_CHANNELS-1:0]  arb_oh_s;
    logic                   arb_any_s;
    logic [BEAT_W-1:0]      beat_cnt_r;
    logic [GAP_CNT_W-1:0]   gap_cnt_r;
    logic [GAP_CNT_W-1:0]   gap_len_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    logic                   trunc_r;
    logic                   src_valid_s;
    logic                   src_last_s;
    logic [P_DATA_W-1:0]    src_data_s;
    logic                   accept_s;
    logic                   max_beat_s;
    logic                   gap_end_s;
    logic                   grant_load_s;
    logic                   gap_load_s;
    logic                   frame_done_s;
    logic                   trunc_s;

    udp_rr_arbiter #(
        .N     (P_CHANNELS),
        .IDX_W (CHAN_W)
    ) u_arb (
        .req     (i_req),
        .ptr     (ptr_r),
        .gnt_oh  (arb_oh_s),
        .gnt_idx (arb_idx_s),
        .gnt_any (arb_any_s)
    );

    // Select the granted channel's beat signals.
    always_comb begin
        src_valid_s = 1'b0;
        src_last_s  = 1'b0;
        src_data_s  = '0;
        for (int k = 0; k < P_CHANNELS; k++) begin
            src_valid_s = (grant_r == CHAN_W'(k)) ? i_valid[k] : src_valid_s;
            src_last_s  = (grant_r == CHAN_W'(k)) ? i_last[k] : src_last_s;
            src_data_s  = (grant_r == CHAN_W'(k)) ? i_data[k*P_DATA_W +: P_DATA_W] : src_data_s;
        end
    end

    assign accept_s   = src_valid_s & i_mac_ready;
    assign max_beat_s = (beat_cnt_r == BEAT_W'(P_MAX_LEN - 1));
    assign gap_end_s  = (gap_cnt_r == (gap_len_r - GAP_CNT_W'(1)));

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic plus the one-cycle event strobes that drive the counters.
    always_comb begin
        state_nx_s   = state_r;
        grant_load_s = 1'b0;
        gap_load_s   = 1'b0;
        frame_done_s = 1'b0;
        trunc_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    state_nx_s   = ST_SEND;
                    grant_load_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (accept_s && src_last_s) begin
                    state_nx_s   = ST_GAP;
                    gap_load_s   = 1'b1;
                    frame_done_s = 1'b1;
                end else if (accept_s && max_beat_s) begin
                    state_nx_s   = ST_DROP;
                    frame_done_s = 1'b1;
                    trunc_s      = 1'b1;
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_DROP: begin
                if (src_valid_s && src_last_s) begin
                    state_nx_s = ST_GAP;
                    gap_load_s = 1'b1;
                end else begin
                    state_nx_s = ST_DROP;
                end
            end
            ST_GAP: begin
                if (gap_end_s && arb_any_s) begin
                    state_nx_s   = ST_SEND;
                    grant_load_s = 1'b1;
                end else if (gap_end_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Beat-path outputs: combinational pass-through from the granted source.
    always_comb begin
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_data  = '0;
        o_ready = '0;
        case (state_r)
            ST_SEND: begin
                o_valid = src_valid_s;
                o_last  = src_last_s | max_beat_s;
                o_data  = src_data_s;
                o_ready = i_mac_ready ? grant_oh_r : '0;
            end
            ST_DROP: begin
                o_ready = grant_oh_r;
            end
            default: begin
                o_valid = 1'b0;
            end
        endcase
    end

    // Grant and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            grant_r    <= '0;
            grant_oh_r <= '0;
            ptr_r      <= '0;
        end else if (grant_load_s) begin
            grant_r    <= arb_idx_s;
            grant_oh_r <= arb_oh_s;
            ptr_r      <= (arb_idx_s == CHAN_W'(P_CHANNELS - 1)) ? '0 : arb_idx_s + CHAN_W'(1);
        end else begin
            grant_r    <= grant_r;
            grant_oh_r <= grant_oh_r;
            ptr_r      <= ptr_r;
        end
    end

    // Beat and gap counters; the gap length is captured when GAP is entered.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            beat_cnt_r <= '0;
            gap_cnt_r  <= '0;
            gap_len_r  <= '0;
        end else begin
            if (grant_load_s) begin
                beat_cnt_r <= '0;
            end else if ((state_r == ST_SEND) && accept_s) begin
                beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            if (gap_load_s) begin
                gap_cnt_r <= '0;
                gap_len_r <= (i_gap_cfg != '0) ? GAP_CNT_W'(i_gap_cfg) : GAP_CNT_W'(P_FRAME_GAP);
            end else if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + GAP_CNT_W'(1);
                gap_len_r <= gap_len_r;
            end else begin
                gap_cnt_r <= gap_cnt_r;
                gap_len_r <= gap_len_r;
            end
        end
    end

    // Frame counter and truncation pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            frame_cnt_r <= '0;
            trunc_r     <= 1'b0;
        end else begin
            frame_cnt_r <= frame_done_s ? frame_cnt_r + 16'd1 : frame_cnt_r;
            trunc_r     <= trunc_s;
        end
    end

    assign o_chan      = grant_r;
    assign o_busy      = (state_r != ST_IDLE);
    assign o_trunc     = trunc_r;
    assign o_frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_udp_tx_ready_ctrl.sv
// Directed self-checking bench for udp_tx_ready_ctrl (2 channels, max frame 8 beats).
module tb_udp_tx_ready_ctrl;

    localparam int NCH  = 2;
    localparam int DW   = 8;
    localparam int MAXL = 8;
    localparam int GW   = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [GW-1:0]     i_gap_cfg;
    logic [NCH-1:0]    i_req;
    logic [NCH-1:0]    i_valid;
    logic [NCH-1:0]    i_last;
    logic [NCH*DW-1:0] i_data;
    logic [NCH-1:0]    o_ready;
    logic              o_valid;
    logic              o_last;
    logic [DW-1:0]     o_data;
    logic [0:0]        o_chan;
    logic              i_mac_ready;
    logic              o_busy;
    logic              o_trunc;
    logic [15:0]       o_frame_cnt;

    always #5 i_clk = ~i_clk;

    udp_tx_ready_ctrl #(
        .P_FRAME_GAP (12),
        .P_CHANNELS  (NCH),
        .P_DATA_W    (DW),
        .P_MAX_LEN   (MAXL),
        .P_GAP_W     (GW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_gap_cfg   (i_gap_cfg),
        .i_req       (i_req),
        .i_valid     (i_valid),
        .i_last      (i_last),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_last      (o_last),
        .o_data      (o_data),
        .o_chan      (o_chan),
        .i_mac_ready (i_mac_ready),
        .o_busy      (o_busy),
        .o_trunc     (o_trunc),
        .o_frame_cnt (o_frame_cnt)
    );

    int chk_cnt = 0;
    int err_cnt = 0;

    // Source model and capture log.
    int         rem[NCH];
    int         nfr[NCH];
    int         flen[NCH];
    logic [7:0] dnx[NCH];
    int         cyc = 0;
    int         mac_mode = 0;
    int         lg_cyc[$];
    int         lg_dat[$];
    int         lg_chn[$];
    int         lg_lst[$];
    int         trunc_cnt = 0;
    int         trunc_cyc = -1;
    int         c0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int k, input int len, input int n, input logic [7:0] d0);
        rem[k]  = len;
        flen[k] = len;
        nfr[k]  = n - 1;
        dnx[k]  = d0;
    endtask

    task automatic clr_log();
        lg_cyc.delete();
        lg_dat.delete();
        lg_chn.delete();
        lg_lst.delete();
        trunc_cnt = 0;
        trunc_cyc = -1;
    endtask

    // One clock: present source beats, observe outputs, then advance the source on handshake.
    task automatic tick();
        logic [NCH-1:0] rdy;
        for (int k = 0; k < NCH; k++) begin
            i_valid[k]          = (rem[k] > 0);
            i_last[k]           = (rem[k] == 1);
            i_req[k]            = (rem[k] > 0);
            i_data[k*DW +: DW]  = dnx[k];
        end
        i_mac_ready = (mac_mode == 0) ? 1'b1 : cyc[0];
        #1;
        if (o_valid && i_mac_ready) begin
            lg_cyc.push_back(cyc);
            lg_dat.push_back(int'(o_data));
            lg_chn.push_back(int'(o_chan));
            lg_lst.push_back(int'(o_last));
        end
        if (o_trunc) begin
            trunc_cnt++;
            trunc_cyc = cyc;
        end
        rdy = o_ready;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < NCH; k++) begin
            if (rdy[k] && i_valid[k]) begin
                rem[k]--;
                dnx[k] = dnx[k] + 8'd1;
                if (rem[k] == 0 && nfr[k] > 0) begin
                    rem[k] = flen[k];
                    nfr[k]--;
                end
            end
        end
        cyc++;
    endtask

    // Clock until all loaded frames are consumed and the controller is idle, within a budget.
    task automatic run_frames(input string tag, input int budget, output int start);
        int n;
        start = cyc;
        tick();
        n = 1;
        while ((rem[0] > 0 || rem[1] > 0 || o_busy) && n < budget) begin
            tick();
            n++;
        end
        check_val({tag, "_done"}, 32'((rem[0] == 0) && (rem[1] == 0) && !o_busy), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_valid"}, 32'(o_valid), 32'd0);
        check_val({tag, "_ready"}, 32'(o_ready), 32'd0);
        check_val({tag, "_last"}, 32'(o_last), 32'd0);
        check_val({tag, "_trunc"}, 32'(o_trunc), 32'd0);
        check_val({tag, "_busy"}, 32'(o_busy), 32'd0);
        check_val({tag, "_chan"}, 32'(o_chan), 32'd0);
        check_val({tag, "_fcnt"}, 32'(o_frame_cnt), 32'd0);
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < NCH; k++) begin
            rem[k] = 0;
            nfr[k] = 0;
        end
        i_req   = '0;
        i_valid = '0;
        i_last  = '0;
        i_data  = '0;
    endtask

    initial begin
        i_rst       = 1'b0;
        i_gap_cfg   = 8'd0;
        i_mac_ready = 1'b1;
        idle_inputs();
        repeat (2) @(posedge i_clk);
        #1;
        check_reset("por");
        i_rst = 1'b1;

        // 1: reset mid-frame abandons the frame
        load(0, 10, 1, 8'h00);
        repeat (3) tick();
        check_val("t1_busy_pre", 32'(o_busy), 32'd1);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check_reset("t1");
        idle_inputs();
        i_rst = 1'b1;

        // 2: two 4-beat frames, default gap of 12, ch0 first after reset
        clr_log();
        i_gap_cfg = 8'd0;
        load(0, 4, 1, 8'h00);
        load(1, 4, 1, 8'h80);
        run_frames("t2", 200, c0);
        check_val("t2_nbeats", 32'(lg_dat.size()), 32'd8);
        if (lg_dat.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_val($sformatf("t2_dat%0d", i), 32'(lg_dat[i]), (i < 4) ? 32'(i) : 32'(128 + i - 4));
                check_val($sformatf("t2_chn%0d", i), 32'(lg_chn[i]), 32'(i / 4));
                check_val($sformatf("t2_lst%0d", i), 32'(lg_lst[i]), 32'((i % 4) == 3));
            end
            check_val("t2_latency", 32'(lg_cyc[0] - c0), 32'd1);
            check_val("t2_contig", 32'(lg_cyc[3] - lg_cyc[0]), 32'd3);
            check_val("t2_gap", 32'(lg_cyc[4] - lg_cyc[3] - 1), 32'd12);
        end
        check_val("t2_fcnt", 32'(o_frame_cnt), 32'd2);

        // 3: runtime gap of 3 between back-to-back ch0 frames
        clr_log();
        i_gap_cfg = 8'd3;
        load(0, 4, 2, 8'h10);
        run_frames("t3", 200, c0);
        check_val("t3_nbeats", 32'(lg_dat.size()), 32'd8);
        if (lg_dat.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_val($sformatf("t3_dat%0d", i), 32'(lg_dat[i]), 32'(16 + i));
                check_val($sformatf("t3_lst%0d", i), 32'(lg_lst[i]), 32'((i % 4) == 3));
            end
            check_val("t3_gap", 32'(lg_cyc[4] - lg_cyc[3] - 1), 32'd3);
        end
        check_val("t3_fcnt", 32'(o_frame_cnt), 32'd4);

        // 4: 11-beat ch1 frame truncated at 8 beats
        clr_log();
        load(1, 11, 1, 8'h40);
        run_frames("t4", 200, c0);
        check_val("t4_nbeats", 32'(lg_dat.size()), 32'd8);
        if (lg_dat.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check_val($sformatf("t4_dat%0d", i), 32'(lg_dat[i]), 32'(64 + i));
                check_val($sformatf("t4_chn%0d", i), 32'(lg_chn[i]), 32'd1);
                check_val($sformatf("t4_lst%0d", i), 32'(lg_lst[i]), 32'(i == 7));
            end
            check_val("t4_trunc_time", 32'(trunc_cyc), 32'(lg_cyc[7] + 1));
        end
        check_val("t4_trunc_cnt", 32'(trunc_cnt), 32'd1);
        check_val("t4_fcnt", 32'(o_frame_cnt), 32'd5);

        // 5: MAC ready toggling every cycle during a 6-beat frame
        clr_log();
        mac_mode = 1;
        load(0, 6, 1, 8'h20);
        run_frames("t5", 200, c0);
        mac_mode = 0;
        check_val("t5_nbeats", 32'(lg_dat.size()), 32'd6);
        if (lg_dat.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check_val($sformatf("t5_dat%0d", i), 32'(lg_dat[i]), 32'(32 + i));
                check_val($sformatf("t5_lst%0d", i), 32'(lg_lst[i]), 32'(i == 5));
            end
        end
        check_val("t5_trunc_cnt", 32'(trunc_cnt), 32'd0);
        check_val("t5_fcnt", 32'(o_frame_cnt), 32'd6);

        // 6: reset to put the pointer at ch0, then only ch1 requests; pointer wraps to ch0
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check_reset("t6_rst");
        i_rst = 1'b1;
        clr_log();
        load(1, 2, 1, 8'h60);
        run_frames("t6a", 200, c0);
        check_val("t6a_nbeats", 32'(lg_dat.size()), 32'd2);
        if (lg_dat.size() == 2) begin
            check_val("t6a_latency", 32'(lg_cyc[0] - c0), 32'd1);
            check_val("t6a_chn", 32'(lg_chn[0]), 32'd1);
            check_val("t6a_dat", 32'(lg_dat[1]), 32'h61);
        end
        clr_log();
        load(0, 1, 1, 8'h00);
        load(1, 1, 1, 8'h70);
        run_frames("t6b", 200, c0);
        check_val("t6b_nbeats", 32'(lg_dat.size()), 32'd2);
        if (lg_dat.size() == 2) begin
            check_val("t6b_chn0", 32'(lg_chn[0]), 32'd0);
            check_val("t6b_chn1", 32'(lg_chn[1]), 32'd1);
            check_val("t6b_dat1", 32'(lg_dat[1]), 32'h70);
        end
        check_val("t6_fcnt", 32'(o_frame_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
